// File: rtl/eth_measurer_pkg.sv
// Shared types for the Ethernet latency measurer blocks.
// The scheduler state encoding is exported here so debug taps can decode it.
package eth_measurer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_TRIGGER     = 3'd1,
    ST_WAIT_REPLY  = 3'd2,
    ST_REPORT      = 3'd3,
    ST_WAIT_PERIOD = 3'd4
  } sched_state_e;

endpackage

// File: rtl/eth_measurer_sched.sv
// Probe scheduler: launches one probe per period, times the reply or declares
// it lost, and keeps running sent/lost totals.
module eth_measurer_sched #(
  parameter int counter_width = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_enable,
  input  logic [counter_width-1:0] cfg_period,
  input  logic [counter_width-1:0] cfg_timeout,
  input  logic [15:0]              cfg_padding_size,
  output logic                     tx_trigger,
  output logic [15:0]              tx_padding_size,
  input  logic                     tx_begin,
  input  logic                     rx_done,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     result_lost,
  output logic [counter_width-1:0] result_latency,
  output logic [counter_width-1:0] probes_sent,
  output logic [counter_width-1:0] probes_lost
);
  import eth_measurer_pkg::*;

  localparam logic [counter_width-1:0] cnt_ones = '1;
  localparam logic [counter_width-1:0] cnt_one  = counter_width'(1);
  localparam logic [counter_width-1:0] cnt_zero = '0;

  function automatic logic [counter_width-1:0] sat_inc(input logic [counter_width-1:0] v);
    if (v == cnt_ones) begin
      return v;
    end else begin
      return v + cnt_one;
    end
  endfunction

  sched_state_e state;
  sched_state_e next_state;
  logic [counter_width-1:0] lat_cnt;
  logic [counter_width-1:0] per_cnt;
  logic [counter_width-1:0] lat_elapsed;
  logic [counter_width-1:0] per_elapsed;
  logic timeout_hit;
  logic period_done;

  // Counters hold cycles-since-tx_begin minus one, so elapsed time is count + 1.
  assign lat_elapsed = sat_inc(lat_cnt);
  assign per_elapsed = sat_inc(per_cnt);
  assign timeout_hit = (cfg_timeout != cnt_zero) && (lat_cnt == (cfg_timeout - cnt_one));
  assign period_done = (cfg_period <= cnt_one) || (per_elapsed >= (cfg_period - cnt_one));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cfg_enable) next_state = ST_TRIGGER;
        else            next_state = ST_IDLE;
      end
      ST_TRIGGER: begin
        if (tx_begin) next_state = ST_WAIT_REPLY;
        else          next_state = ST_TRIGGER;
      end
      ST_WAIT_REPLY: begin
        if (rx_done || timeout_hit) next_state = ST_REPORT;
        else                        next_state = ST_WAIT_REPLY;
      end
      ST_REPORT: begin
        next_state = ST_WAIT_PERIOD;
      end
      ST_WAIT_PERIOD: begin
        if (!cfg_enable)      next_state = ST_IDLE;
        else if (period_done) next_state = ST_TRIGGER;
        else                  next_state = ST_WAIT_PERIOD;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Counters, statistics and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt         <= cnt_zero;
      per_cnt         <= cnt_zero;
      tx_trigger      <= 1'b0;
      tx_padding_size <= 16'd0;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      result_lost     <= 1'b0;
      result_latency  <= cnt_zero;
      probes_sent     <= cnt_zero;
      probes_lost     <= cnt_zero;
    end else begin
      tx_trigger   <= (next_state == ST_TRIGGER);
      busy         <= (next_state != ST_IDLE);
      result_valid <= (next_state == ST_REPORT);
      if ((state != ST_TRIGGER) && (next_state == ST_TRIGGER)) begin
        tx_padding_size <= cfg_padding_size;
      end
      case (state)
        ST_TRIGGER: begin
          if (tx_begin) begin
            lat_cnt     <= cnt_zero;
            per_cnt     <= cnt_zero;
            probes_sent <= probes_sent + cnt_one;
          end
        end
        ST_WAIT_REPLY: begin
          lat_cnt <= lat_elapsed;
          per_cnt <= per_elapsed;
          // A reply arriving on the timeout cycle wins.
          if (rx_done) begin
            result_latency <= lat_elapsed;
            result_lost    <= 1'b0;
          end else if (timeout_hit) begin
            result_latency <= cnt_zero;
            result_lost    <= 1'b1;
            probes_lost    <= probes_lost + cnt_one;
          end
        end
        ST_REPORT, ST_WAIT_PERIOD: begin
          per_cnt <= per_elapsed;
        end
        default: begin
          per_cnt <= per_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_measurer_sched.sv
// Directed bench for eth_measurer_sched: a probe table plus hand sequences for
// period spacing, disable and reset corner cases.
module tb_eth_measurer_sched;

  logic        clk;
  logic        rst;
  logic        cfg_enable;
  logic [31:0] cfg_period;
  logic [31:0] cfg_timeout;
  logic [15:0] cfg_padding_size;
  logic        tx_trigger;
  logic [15:0] tx_padding_size;
  logic        tx_begin;
  logic        rx_done;
  logic        busy;
  logic        result_valid;
  logic        result_lost;
  logic [31:0] result_latency;
  logic [31:0] probes_sent;
  logic [31:0] probes_lost;

  eth_measurer_sched #(.counter_width(32)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
    .cfg_timeout(cfg_timeout), .cfg_padding_size(cfg_padding_size),
    .tx_trigger(tx_trigger), .tx_padding_size(tx_padding_size),
    .tx_begin(tx_begin), .rx_done(rx_done), .busy(busy),
    .result_valid(result_valid), .result_lost(result_lost),
    .result_latency(result_latency), .probes_sent(probes_sent),
    .probes_lost(probes_lost)
  );

  typedef struct {
    logic [31:0] timeout;
    int          rx_delay;
    logic        exp_lost;
    logic [31:0] exp_lat;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stub_delay = 0;
  int trig_age = 0;
  int tb_cnt = 0;
  int tb_cyc = 0;
  int res_cnt = 0;
  int res_cyc = 0;
  logic [31:0] res_lat = '0;
  logic        res_lost = 1'b0;
  logic [31:0] exp_sent = '0;
  logic [31:0] exp_lost_tot = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // TX engine stub: pulses tx_begin stub_delay cycles after tx_trigger rises.
  initial begin
    tx_begin = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_trigger) begin
        if (trig_age == stub_delay) begin
          tx_begin = 1'b1;
          tb_cnt++;
          tb_cyc = cyc;
        end else begin
          tx_begin = 1'b0;
        end
        trig_age++;
      end else begin
        tx_begin = 1'b0;
        trig_age = 0;
      end
    end
  end

  // Result capture.
  initial forever begin
    @(negedge clk);
    if (result_valid === 1'b1) begin
      res_cnt++;
      res_cyc  = cyc;
      res_lat  = result_latency;
      res_lost = result_lost;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_trigger"}, 64'(tx_trigger), 64'd0);
    check({tag, "_tx_padding"}, 64'(tx_padding_size), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    check({tag, "_result_lost"}, 64'(result_lost), 64'd0);
    check({tag, "_result_latency"}, 64'(result_latency), 64'd0);
    check({tag, "_probes_sent"}, 64'(probes_sent), 64'd0);
    check({tag, "_probes_lost"}, 64'(probes_lost), 64'd0);
  endtask

  task automatic wait_tx_begin(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (tx_begin) break;
    end
  endtask

  task automatic wait_result(input int r0, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (res_cnt != r0) break;
      tick();
    end
  endtask

  task automatic pulse_rx();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  initial begin
    int e, c1, r0, t0, bound;
    logic saw_trigger;

    vecs[0] = '{32'd500, 37,    1'b0, 32'd37};
    vecs[1] = '{32'd100, -1,    1'b1, 32'd0};
    vecs[2] = '{32'd99,  99,    1'b0, 32'd99};
    vecs[3] = '{32'd0,   1,     1'b0, 32'd1};
    vecs[4] = '{32'd5,   6,     1'b1, 32'd0};
    vecs[5] = '{32'd2,   1,     1'b0, 32'd1};
    vecs[6] = '{32'd0,   70000, 1'b0, 32'd70000};

    rst = 1'b1;
    cfg_enable = 1'b0;
    cfg_period = 32'd1000;
    cfg_timeout = 32'd500;
    cfg_padding_size = 16'h0040;
    rx_done = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Periodic probing with an immediate TX engine: spacing must equal cfg_period.
    stub_delay = 0;
    cfg_enable = 1'b1;
    e = cyc;
    wait_tx_begin(20);
    check("trigger_rise_delay", 64'(tb_cyc - e), 64'd1);
    c1 = tb_cyc;
    exp_sent = exp_sent + 32'd1;
    r0 = res_cnt;
    cfg_padding_size = 16'h0080;
    repeat (37) tick();
    pulse_rx();
    wait_result(r0, 10);
    check("p1_count", 64'(res_cnt - r0), 64'd1);
    check("p1_latency", 64'(res_lat), 64'd37);
    check("p1_lost", 64'(res_lost), 64'd0);
    check("p1_valid_delay", 64'(res_cyc - c1), 64'd38);
    check("p1_padding_held", 64'(tx_padding_size), 64'h0040);
    check("p1_sent", 64'(probes_sent), 64'(exp_sent));
    wait_tx_begin(1100);
    check("period_spacing", 64'(tb_cyc - c1), 64'd1000);
    check("p2_padding", 64'(tx_padding_size), 64'h0080);
    exp_sent = exp_sent + 32'd1;
    cfg_enable = 1'b0;
    r0 = res_cnt;
    repeat (37) tick();
    pulse_rx();
    wait_result(r0, 10);
    check("p2_count", 64'(res_cnt - r0), 64'd1);
    check("p2_latency", 64'(res_lat), 64'd37);
    check("p2_sent", 64'(probes_sent), 64'(exp_sent));
    t0 = tb_cnt;
    saw_trigger = 1'b0;
    repeat (3) tick();
    check("disable_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (tx_trigger) saw_trigger = 1'b1;
    end
    check("disable_no_trigger", 64'(saw_trigger), 64'd0);
    check("disable_no_tx_begin", 64'(tb_cnt - t0), 64'd0);

    // Single-probe table: enable, drop enable once the probe is launched.
    stub_delay = 2;
    cfg_period = 32'd4;
    foreach (vecs[k]) begin
      cfg_timeout = vecs[k].timeout;
      cfg_enable = 1'b1;
      e = cyc;
      wait_tx_begin(20);
      check($sformatf("v%0d_trigger_to_begin", k), 64'(tb_cyc - e), 64'd3);
      cfg_enable = 1'b0;
      c1 = tb_cyc;
      r0 = res_cnt;
      exp_sent = exp_sent + 32'd1;
      if (vecs[k].exp_lost) exp_lost_tot = exp_lost_tot + 32'd1;
      if (vecs[k].rx_delay > 0) begin
        repeat (vecs[k].rx_delay) tick();
        pulse_rx();
      end
      bound = (vecs[k].rx_delay > 0) ? vecs[k].rx_delay + 20 : int'(vecs[k].timeout) + 20;
      wait_result(r0, bound);
      repeat (5) tick();
      check($sformatf("v%0d_count", k), 64'(res_cnt - r0), 64'd1);
      check($sformatf("v%0d_lost", k), 64'(res_lost), 64'(vecs[k].exp_lost));
      check($sformatf("v%0d_latency", k), 64'(res_lat), 64'(vecs[k].exp_lat));
      check($sformatf("v%0d_valid_delay", k), 64'(res_cyc - c1),
            vecs[k].exp_lost ? 64'(vecs[k].timeout) + 64'd1 : 64'(vecs[k].rx_delay) + 64'd1);
      check($sformatf("v%0d_sent", k), 64'(probes_sent), 64'(exp_sent));
      check($sformatf("v%0d_lost_total", k), 64'(probes_lost), 64'(exp_lost_tot));
      check($sformatf("v%0d_idle", k), 64'(busy), 64'd0);
    end

    // Reset while waiting for a reply: probe dropped, later reply ignored.
    cfg_timeout = 32'd0;
    cfg_enable = 1'b1;
    wait_tx_begin(20);
    cfg_enable = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    r0 = res_cnt;
    repeat (5) tick();
    pulse_rx();
    repeat (10) tick();
    check("midrst_no_result", 64'(res_cnt - r0), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);
    check("midrst_sent", 64'(probes_sent), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
